mem_access_unit: RTL and testbench

//  Initiator side of the word RAM port (a/wd/we/rd): turns CPU load/store requests
//  (byte/half/word, any byte address) into word-indexed RAM accesses. Sub-word stores use

---
 rtl/mem_access_unit.sv | 204 ++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 390 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// ----------------------------------------------------------------------------
// mem_access_unit
//   Initiator side of a word-wide data RAM port. Takes one CPU load/store
//   request at a time (byte/half/word, any byte address) and turns it into
//   word-indexed RAM accesses. The RAM has no byte enables, so every store
//   first reads the addressed word and then writes back a merged word.
//   Requests that are misaligned, use the illegal size or index past the end
//   of the RAM complete at once with rsp_err set and never touch the RAM.
//
// Ports
//   clk, rst            clock; asynchronous active-low reset
//   req_valid/req_ready request handshake
//   req_we              1 = store, 0 = load
//   req_size            00 byte, 01 half, 10 word, 11 illegal
//   req_signed          load result sign-extended when 1
//   req_addr            byte address
//   req_wdata           store data, right-aligned
//   rsp_valid/rsp_ready response handshake
//   rsp_rdata           extended load result (0 for stores and errors)
//   rsp_err             request rejected
//   mem_a               RAM word index
//   mem_wd, mem_we      RAM write data / write enable
//   mem_rd              RAM read data, combinational from mem_a
// ----------------------------------------------------------------------------
module mem_access_unit #(
    parameter int MEM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] mem_a,
    output logic [31:0] mem_wd,
    output logic        mem_we,
    input  logic [31:0] mem_rd
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WRITE  = 2'd2,
        RSP    = 2'd3
    } state_t;

    localparam logic [29:0] IDX_LIMIT = 30'(MEM_WORDS);

    state_t      state;
    state_t      state_nx;

    logic        req_fire;
    logic        req_bad;

    // Latched request and the merged store word
    logic        we_q;
    logic [1:0]  size_q;
    logic        signed_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] merged_q;

    // Select the addressed lane(s) of a word and extend to 32 bits.
    function automatic logic [31:0] load_extract(input logic [31:0] word,
                                                 input logic [1:0]  lane,
                                                 input logic [1:0]  size,
                                                 input logic        sgn);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{lane, 3'b000} +: 8];
        h = word[{lane[1], 4'b0000} +: 16];
        case (size)
            2'b00:   r = {{24{sgn & b[7]}}, b};
            2'b01:   r = {{16{sgn & h[15]}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

    // Replace the addressed lane(s) of the old word with the low store bits.
    function automatic logic [31:0] store_merge(input logic [31:0] word,
                                                input logic [31:0] wdata,
                                                input logic [1:0]  lane,
                                                input logic [1:0]  size);
        logic [31:0] r;
        r = word;
        case (size)
            2'b00:   r[{lane, 3'b000} +: 8]     = wdata[7:0];
            2'b01:   r[{lane[1], 4'b0000} +: 16] = wdata[15:0];
            default: r = wdata;
        endcase
        return r;
    endfunction

    assign req_fire = req_valid & req_ready;

    // Request validity, judged on the live request inputs at the handshake.
    always_comb begin
        req_bad = 1'b0;
        case (req_size)
            2'b00:   req_bad = 1'b0;
            2'b01:   req_bad = req_addr[0];
            2'b10:   req_bad = |req_addr[1:0];
            default: req_bad = 1'b1;
        endcase
        if (req_addr[31:2] >= IDX_LIMIT) begin
            req_bad = 1'b1;
        end
    end

    // Next state
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (req_fire) state_nx = req_bad ? RSP : ACCESS;
            ACCESS:  state_nx = we_q ? WRITE : RSP;
            WRITE:   state_nx = RSP;
            RSP:     if (rsp_valid && rsp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // RAM port is driven straight from the state so that an asynchronous
    // reset drops mem_we immediately, without waiting for a clock.
    always_comb begin
        mem_a  = 32'd0;
        mem_wd = 32'd0;
        mem_we = 1'b0;
        if (state == ACCESS || state == WRITE) begin
            mem_a = {2'b00, addr_q[31:2]};
        end
        if (state == WRITE) begin
            mem_wd = merged_q;
            mem_we = 1'b1;
        end
    end

    // Control and response registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
        end else begin
            state     <= state_nx;
            // Registered so it stays low throughout reset and rises one
            // edge after release.
            req_ready <= (state_nx == IDLE);
            case (state)
                IDLE: begin
                    if (req_fire && req_bad) begin
                        rsp_rdata <= 32'd0;
                        rsp_err   <= 1'b1;
                    end
                end
                ACCESS: begin
                    if (!we_q) begin
                        rsp_rdata <= load_extract(mem_rd, addr_q[1:0], size_q, signed_q);
                        rsp_err   <= 1'b0;
                    end
                end
                WRITE: begin
                    rsp_rdata <= 32'd0;
                    rsp_err   <= 1'b0;
                end
                RSP: begin
                    // First RSP cycle raises rsp_valid; data is already stable.
                    if (!rsp_valid) begin
                        rsp_valid <= 1'b1;
                    end else if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Request capture and store merge; these only matter while the FSM
    // is busy, so they carry no reset.
    always_ff @(posedge clk) begin
        if (req_fire) begin
            we_q     <= req_we;
            size_q   <= req_size;
            signed_q <= req_signed;
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
        end
        if (state == ACCESS) begin
            merged_q <= store_merge(mem_rd, wdata_q, addr_q[1:0], size_q);
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] mem_a;
    logic [31:0] mem_wd;
    logic        mem_we;
    logic [31:0] mem_rd;

    int checks = 0;
    int errors = 0;

    // Bench RAM model
    logic [31:0] ram [0:1023];
    logic        pre_we = 1'b0;
    logic [9:0]  pre_a  = '0;
    logic [31:0] pre_d  = '0;
    int          we_cnt = 0;
    logic [31:0] last_we_a = '0;

    assign mem_rd = (mem_a < 32'd1024) ? ram[mem_a[9:0]] : 32'hBAD0BAD0;

    always @(posedge clk) begin
        if (mem_we) begin
            ram[mem_a[9:0]] <= mem_wd;
            we_cnt          <= we_cnt + 1;
            last_we_a       <= mem_a;
        end else if (pre_we) begin
            ram[pre_a] <= pre_d;
        end
    end

    mem_access_unit #(.MEM_WORDS(1024)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .mem_a      (mem_a),
        .mem_wd     (mem_wd),
        .mem_we     (mem_we),
        .mem_rd     (mem_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] rd;
    logic        er;
    int          lat;

    task automatic preload(input logic [9:0] a, input logic [31:0] d);
        pre_we = 1'b1;
        pre_a  = a;
        pre_d  = d;
        @(posedge clk); #1;
        pre_we = 1'b0;
    endtask

    // Issue one request, wait (bounded) for the response, and consume it.
    // lat counts edges after the handshake edge until rsp_valid is seen.
    task automatic do_req(input logic we, input logic [1:0] size, input logic sgn,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic err, output int l);
        int w;
        w = 0;
        while (!req_ready && w < 20) begin
            @(posedge clk); #1;
            w++;
        end
        req_valid  = 1'b1;
        req_we     = we;
        req_size   = size;
        req_signed = sgn;
        req_addr   = addr;
        req_wdata  = wdata;
        @(posedge clk); #1;
        req_valid = 1'b0;
        l = 0;
        while (!rsp_valid && l < 20) begin
            @(posedge clk); #1;
            l++;
        end
        rdata = rsp_rdata;
        err   = rsp_err;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || rsp_rdata !== 32'd0 || rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_rsp: valid=%b rdata=%h err=%b, required 0/0/0", rsp_valid, rsp_rdata, rsp_err);
        end
        checks++;
        if (mem_we !== 1'b0 || mem_a !== 32'd0 || mem_wd !== 32'd0 || req_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_mem: we=%b a=%h wd=%h ready=%b, required 0/0/0/0", mem_we, mem_a, mem_wd, req_ready);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: got %b, required 1", req_ready);
        end
    endtask

    task automatic test_word();
        int c0;
        c0 = we_cnt;
        do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, rd, er, lat);
        checks++;
        if (lat !== 3 || er !== 1'b0 || rd !== 32'd0) begin
            errors++;
            $display("FAIL store_word_rsp: lat=%0d err=%b rdata=%h, required 3/0/0", lat, er, rd);
        end
        checks++;
        if (we_cnt - c0 !== 1 || last_we_a !== 32'd4 || ram[4] !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL store_word_ram: pulses=%0d a=%h ram=%h, required 1/4/deadbeef", we_cnt - c0, last_we_a, ram[4]);
        end
        do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, er, lat);
        checks++;
        if (lat !== 2 || er !== 1'b0 || rd !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL load_word: lat=%0d err=%b rdata=%h, required 2/0/deadbeef", lat, er, rd);
        end
    endtask

    task automatic test_subword();
        preload(10'd8, 32'h11223344);
        do_req(1'b1, 2'b00, 1'b0, 32'h22, 32'h123456AA, rd, er, lat);
        checks++;
        if (lat !== 3 || er !== 1'b0 || ram[8] !== 32'h11AA3344) begin
            errors++;
            $display("FAIL store_byte: lat=%0d err=%b ram=%h, required 3/0/11aa3344", lat, er, ram[8]);
        end
        do_req(1'b0, 2'b00, 1'b1, 32'h22, 32'h0, rd, er, lat);
        checks++;
        if (rd !== 32'hFFFFFFAA || er !== 1'b0 || lat !== 2) begin
            errors++;
            $display("FAIL load_byte_signed: rdata=%h err=%b lat=%0d, required ffffffaa/0/2", rd, er, lat);
        end
        do_req(1'b0, 2'b00, 1'b0, 32'h22, 32'h0, rd, er, lat);
        checks++;
        if (rd !== 32'h000000AA) begin
            errors++;
            $display("FAIL load_byte_unsigned: rdata=%h, required 000000aa", rd);
        end
        do_req(1'b0, 2'b01, 1'b1, 32'h22, 32'h0, rd, er, lat);
        checks++;
        if (rd !== 32'h000011AA) begin
            errors++;
            $display("FAIL load_half_signed_22: rdata=%h, required 000011aa", rd);
        end
        do_req(1'b0, 2'b00, 1'b1, 32'h20, 32'h0, rd, er, lat);
        checks++;
        if (rd !== 32'h00000044) begin
            errors++;
            $display("FAIL load_byte_lane0: rdata=%h, required 00000044", rd);
        end
        do_req(1'b0, 2'b00, 1'b0, 32'h23, 32'h0, rd, er, lat);
        checks++;
        if (rd !== 32'h00000011) begin
            errors++;
            $display("FAIL load_byte_lane3: rdata=%h, required 00000011", rd);
        end
        do_req(1'b1, 2'b01, 1'b0, 32'h12, 32'h7777CAFE, rd, er, lat);
        checks++;
        if (ram[4] !== 32'hCAFEBEEF || lat !== 3) begin
            errors++;
            $display("FAIL store_half: ram=%h lat=%0d, required cafebeef/3", ram[4], lat);
        end
        do_req(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, rd, er, lat);
        checks++;
        if (rd !== 32'hFFFFCAFE) begin
            errors++;
            $display("FAIL load_half_signed_12: rdata=%h, required ffffcafe", rd);
        end
        do_req(1'b0, 2'b01, 1'b0, 32'h10, 32'h0, rd, er, lat);
        checks++;
        if (rd !== 32'h0000BEEF) begin
            errors++;
            $display("FAIL load_half_unsigned_10: rdata=%h, required 0000beef", rd);
        end
    endtask

    task automatic test_errors();
        int c0;
        c0 = we_cnt;
        do_req(1'b0, 2'b01, 1'b0, 32'h21, 32'h0, rd, er, lat);
        checks++;
        if (er !== 1'b1 || rd !== 32'd0 || lat !== 1) begin
            errors++;
            $display("FAIL err_half_misaligned: err=%b rdata=%h lat=%0d, required 1/0/1", er, rd, lat);
        end
        do_req(1'b1, 2'b10, 1'b0, 32'h22, 32'h55555555, rd, er, lat);
        checks++;
        if (er !== 1'b1 || rd !== 32'd0 || lat !== 1) begin
            errors++;
            $display("FAIL err_word_misaligned: err=%b rdata=%h lat=%0d, required 1/0/1", er, rd, lat);
        end
        do_req(1'b1, 2'b11, 1'b0, 32'h20, 32'h66666666, rd, er, lat);
        checks++;
        if (er !== 1'b1 || rd !== 32'd0 || lat !== 1) begin
            errors++;
            $display("FAIL err_size11: err=%b rdata=%h lat=%0d, required 1/0/1", er, rd, lat);
        end
        checks++;
        if (we_cnt !== c0 || ram[8] !== 32'h11AA3344) begin
            errors++;
            $display("FAIL err_no_write: pulses=%0d ram=%h, required 0/11aa3344", we_cnt - c0, ram[8]);
        end
    endtask

    task automatic test_range();
        preload(10'd1023, 32'h5A5A1234);
        do_req(1'b0, 2'b10, 1'b0, 32'h1000, 32'h0, rd, er, lat);
        checks++;
        if (er !== 1'b1 || rd !== 32'd0 || lat !== 1) begin
            errors++;
            $display("FAIL range_1024: err=%b rdata=%h lat=%0d, required 1/0/1", er, rd, lat);
        end
        do_req(1'b0, 2'b10, 1'b0, 32'hFFC, 32'h0, rd, er, lat);
        checks++;
        if (er !== 1'b0 || rd !== 32'h5A5A1234 || lat !== 2) begin
            errors++;
            $display("FAIL range_1023: err=%b rdata=%h lat=%0d, required 0/5a5a1234/2", er, rd, lat);
        end
        do_req(1'b0, 2'b10, 1'b0, 32'hFFFFFFFC, 32'h0, rd, er, lat);
        checks++;
        if (er !== 1'b1 || lat !== 1) begin
            errors++;
            $display("FAIL range_top: err=%b lat=%0d, required 1/1", er, lat);
        end
    endtask

    task automatic test_back_to_back();
        int w;
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_size   = 2'b10;
        req_signed = 1'b0;
        req_addr   = 32'h10;
        req_wdata  = 32'h0;
        @(posedge clk); #1;
        // Second request presented immediately and held
        req_size = 2'b00;
        req_addr = 32'h20;
        w = 0;
        while (!rsp_valid && w < 20) begin
            @(posedge clk); #1;
            w++;
        end
        checks++;
        if (w !== 2) begin
            errors++;
            $display("FAIL bp_first_latency: got %0d, required 2", w);
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hCAFEBEEF || rsp_err !== 1'b0 || req_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold_%0d: valid=%b rdata=%h err=%b ready=%b, required 1/cafebeef/0/0",
                         i, rsp_valid, rsp_rdata, rsp_err, req_ready);
            end
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_idle: ready=%b valid=%b, required 1/0", req_ready, rsp_valid);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        checks++;
        if (req_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_second_accept: ready=%b, required 0", req_ready);
        end
        w = 0;
        while (!rsp_valid && w < 20) begin
            @(posedge clk); #1;
            w++;
        end
        checks++;
        if (w !== 2 || rsp_rdata !== 32'h00000044 || rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL bp_second_rsp: lat=%0d rdata=%h err=%b, required 2/00000044/0", w, rsp_rdata, rsp_err);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset_mid_write();
        int c0;
        c0 = we_cnt;
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_size   = 2'b10;
        req_signed = 1'b0;
        req_addr   = 32'h10;
        req_wdata  = 32'h12345678;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (mem_we !== 1'b1 || mem_a !== 32'd4) begin
            errors++;
            $display("FAIL midrst_in_write: we=%b a=%h, required 1/4", mem_we, mem_a);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (mem_we !== 1'b0 || mem_a !== 32'd0) begin
            errors++;
            $display("FAIL midrst_we_drop: we=%b a=%h, required 0/0", mem_we, mem_a);
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL midrst_idle: ready=%b valid=%b, required 1/0", req_ready, rsp_valid);
        end
        checks++;
        if (ram[4] !== 32'hCAFEBEEF || we_cnt !== c0) begin
            errors++;
            $display("FAIL midrst_ram: ram=%h pulses=%0d, required cafebeef/0", ram[4], we_cnt - c0);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL midrst_no_rsp: valid=%b, required 0", rsp_valid);
        end
    endtask

    initial begin
        rst        = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_size   = 2'b00;
        req_signed = 1'b0;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        rsp_ready  = 1'b0;
        test_reset();
        test_word();
        test_subword();
        test_errors();
        test_range();
        test_back_to_back();
        test_reset_mid_write();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
